// File: rtl/rr_mux4_arbiter.sv
// rr_mux4_arbiter: round-robin arbiter sharing one 4:1 data mux among four
// requesters. It issues a registered one-hot grant and its mux select. A grant
// is rotated after HOLD_MAX cycles, which bounds how long any requester waits.
// The selected data is registered and lags the grant by one cycle.

module rr_mux4_arbiter #(
  parameter int unsigned DATA_W   = 1,
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        req,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  input  logic [DATA_W-1:0] d,
  output logic [1:0]        sel,
  output logic [3:0]        gnt,
  output logic              gnt_valid,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid
);

  localparam int unsigned HCNT_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [1:0]        ptr, ptr_nxt;
  logic [HCNT_W-1:0] hcnt, hcnt_nxt;
  logic [1:0]        sel_nxt;
  logic [3:0]        gnt_nxt;
  logic              gnt_valid_nxt;

  logic              release_c;
  logic [1:0]        scan_base_c;
  logic [1:0]        scan_idx_c;
  logic              win_found_c;
  logic [1:0]        win_idx_c;
  logic [DATA_W-1:0] mux_c;

  // Release when the holder drops its request or its tenure is used up.
  always_comb begin
    release_c = (state == GRANT) &&
                (!req[sel] || (hcnt == HCNT_W'(HOLD_MAX - 1)));
  end

  // A release re-arbitrates from the slot after the holder, so the pointer
  // update and the new grant take effect on the same edge.
  always_comb begin
    scan_base_c = (state == GRANT) ? (sel + 2'd1) : ptr;
  end

  // Priority scan from scan_base_c; the loop runs from the farthest offset
  // down so that the nearest requesting slot is the one left in win_idx_c.
  always_comb begin
    win_found_c = 1'b0;
    win_idx_c   = scan_base_c;
    scan_idx_c  = scan_base_c;
    for (int i = 3; i >= 0; i--) begin
      scan_idx_c = scan_base_c + 2'(i);
      if (req[scan_idx_c]) begin
        win_found_c = 1'b1;
        win_idx_c   = scan_idx_c;
      end
    end
  end

  // Data mux indexed by the currently registered select.
  always_comb begin
    mux_c = a;
    case (sel)
      2'd0:    mux_c = a;
      2'd1:    mux_c = b;
      2'd2:    mux_c = c;
      default: mux_c = d;
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= 2'd0;
      hcnt       <= '0;
      sel        <= 2'd0;
      gnt        <= 4'd0;
      gnt_valid  <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      hcnt       <= hcnt_nxt;
      sel        <= sel_nxt;
      gnt        <= gnt_nxt;
      gnt_valid  <= gnt_valid_nxt;
      dout_valid <= gnt_valid;
      if (gnt_valid) begin
        dout <= mux_c;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (win_found_c) begin
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (release_c && !win_found_c) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of grant, select, pointer and hold counter.
  always_comb begin
    sel_nxt       = sel;
    gnt_nxt       = gnt;
    gnt_valid_nxt = gnt_valid;
    hcnt_nxt      = hcnt;
    ptr_nxt       = ptr;
    case (state)
      IDLE: begin
        if (win_found_c) begin
          sel_nxt       = win_idx_c;
          gnt_nxt       = 4'd1 << win_idx_c;
          gnt_valid_nxt = 1'b1;
          hcnt_nxt      = '0;
        end else begin
          gnt_nxt       = 4'd0;
          gnt_valid_nxt = 1'b0;
        end
      end
      GRANT: begin
        if (release_c) begin
          ptr_nxt  = sel + 2'd1;
          hcnt_nxt = '0;
          if (win_found_c) begin
            sel_nxt       = win_idx_c;
            gnt_nxt       = 4'd1 << win_idx_c;
            gnt_valid_nxt = 1'b1;
          end else begin
            gnt_nxt       = 4'd0;
            gnt_valid_nxt = 1'b0;
          end
        end else begin
          hcnt_nxt = hcnt + HCNT_W'(1);
        end
      end
      default: begin
        gnt_nxt       = 4'd0;
        gnt_valid_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Bench for rr_mux4_arbiter. Expected outputs come from a grant-ownership
// model and go into a queue. A monitor pops one entry per clock edge and
// compares it against the outputs.

module tb_rr_mux4_arbiter;

  localparam int unsigned DW   = 4;
  localparam int unsigned HOLD = 4;

  typedef struct packed {
    logic [1:0]    sel;
    logic [3:0]    gnt;
    logic          gv;
    logic [DW-1:0] dout;
    logic          dv;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req;
  logic [DW-1:0] din [4];
  logic [1:0]    sel;
  logic [3:0]    gnt;
  logic          gnt_valid;
  logic [DW-1:0] dout;
  logic          dout_valid;

  int total = 0;
  int bad   = 0;
  exp_t q[$];

  // Model of who owns the mux
  bit            m_active = 1'b0;
  int            m_owner  = 0;
  int            m_tenure = 0;
  int            m_ptr    = 0;
  int            m_sel    = 0;
  logic [DW-1:0] m_dout   = '0;
  bit            m_dv     = 1'b0;
  int            wait_cnt [4];

  rr_mux4_arbiter #(.DATA_W(DW), .HOLD_MAX(HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .a         (din[0]),
    .b         (din[1]),
    .c         (din[2]),
    .d         (din[3]),
    .sel       (sel),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .dout      (dout),
    .dout_valid(dout_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Give the mux to the first requester found going round from 'start'.
  task automatic pick(input int start, input logic [3:0] rq);
    bit found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      int j = (start + k) % 4;
      if (!found && rq[j]) begin
        found    = 1'b1;
        m_owner  = j;
        m_sel    = j;
        m_tenure = 1;
      end
    end
    m_active = found;
  endtask

  // Work out the outputs for the next edge, given the inputs now applied.
  task automatic model_step(input bit r, input logic [3:0] rq);
    exp_t e;
    if (r) begin
      m_active = 1'b0; m_owner = 0; m_tenure = 0; m_ptr = 0; m_sel = 0;
      m_dout   = '0;   m_dv = 1'b0;
    end else begin
      if (m_active) m_dout = din[m_sel];
      m_dv = m_active;
      if (!m_active) begin
        pick(m_ptr, rq);
      end else if (!rq[m_owner] || m_tenure == HOLD) begin
        m_ptr = (m_owner + 1) % 4;
        pick(m_ptr, rq);
      end else begin
        m_tenure++;
      end
    end
    e.sel  = 2'(m_sel);
    e.gnt  = m_active ? (4'd1 << m_owner) : 4'd0;
    e.gv   = m_active;
    e.dout = m_dout;
    e.dv   = m_dv;
    q.push_back(e);
  endtask

  // Apply n cycles of the given rst/req with random data.
  task automatic cyc(input bit r, input logic [3:0] rq, input int n);
    for (int i = 0; i < n; i++) begin
      rst = r;
      req = rq;
      for (int k = 0; k < 4; k++) din[k] = DW'($urandom);
      model_step(r, rq);
      @(negedge clk);
    end
  endtask

  // Monitor: one expected entry per edge, plus invariants and a starvation bound.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
        chk("queue_underflow", 32'(q.size()), 32'd1);
      end else begin
        e = q.pop_front();
        chk("sel",        32'(sel),        32'(e.sel));
        chk("gnt",        32'(gnt),        32'(e.gnt));
        chk("gnt_valid",  32'(gnt_valid),  32'(e.gv));
        chk("dout",       32'(dout),       32'(e.dout));
        chk("dout_valid", 32'(dout_valid), 32'(e.dv));
        chk("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
        chk("gv_eq_orgnt", 32'(gnt_valid), 32'(|gnt));
        for (int i = 0; i < 4; i++) begin
          if (rst || !req[i] || gnt[i]) begin
            wait_cnt[i] = 0;
          end else begin
            wait_cnt[i]++;
            chk($sformatf("starve_%0d", i), 32'(wait_cnt[i] <= 3 * HOLD + 1), 32'd1);
          end
        end
      end
    end
  end

  initial begin
    logic [3:0] rq;
    for (int i = 0; i < 4; i++) begin
      din[i]      = '0;
      wait_cnt[i] = 0;
    end
    // Reset with all requesting, then fair rotation with sel wrapping
    cyc(1'b1, 4'b1111, 2);
    cyc(1'b0, 4'b1111, 20);
    cyc(1'b0, 4'b0000, 2);
    // Single requester b, then drop it
    cyc(1'b0, 4'b0010, 3);
    cyc(1'b0, 4'b0000, 2);
    // Early release from a to c
    cyc(1'b1, 4'b0000, 1);
    cyc(1'b0, 4'b0101, 2);
    cyc(1'b0, 4'b0100, 3);
    cyc(1'b0, 4'b0000, 1);
    // Timeout re-grant with only d requesting
    cyc(1'b0, 4'b1000, 20);
    // Reset mid-grant of c; arbitration restarts at a
    cyc(1'b0, 4'b0100, 3);
    cyc(1'b1, 4'b1100, 1);
    cyc(1'b0, 4'b1100, 6);
    // Random traffic with sticky requests and rare resets
    rq = 4'b0000;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
      cyc(($urandom_range(0, 63) == 0), rq, 1);
    end
    cyc(1'b0, 4'b0000, 2);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_mux4_arbiter.md
Name: rr_mux4_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 4:1 data mux among four requesters (a, b, c, d) on the Basys 3 design.
- Owns the 2-bit mux select and issues a one-hot grant.
- Registers the selected data and forces rotation after a bounded hold time, so no requester can starve the others.

Parameters:
- DATA_W, 1, width of each requester data input and of dout.
- HOLD_MAX, 8, maximum consecutive cycles one grant may be held before forced rotation (legal range 2..255).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request lines; bit0=a, bit1=b, bit2=c, bit3=d.
- a  input  DATA_W  requester 0 data.
- b  input  DATA_W  requester 1 data.
- c  input  DATA_W  requester 2 data.
- d  input  DATA_W  requester 3 data.
- sel  output  2  mux select of the current grant (0=a .. 3=d); registered.
- gnt  output  4  one-hot grant, equal to 1<<sel when gnt_valid, else 0; registered.
- gnt_valid  output  1  a grant is active.
- dout  output  DATA_W  registered mux output.
- dout_valid  output  1  dout holds data from a granted requester.

Behaviour:
- Reset (rst=1 at a clock edge):
  - sel=0, gnt=0, gnt_valid=0, dout=0, dout_valid=0.
  - Internal priority pointer ptr=0 (requester a highest priority); hold counter hcnt=0.
  - State is IDLE.
  - rst overrides all other inputs, including during an active grant.
- FSM states: IDLE and GRANT.
- Arbitration function (combinational):
  - Scan req starting at index ptr, then ptr+1, ptr+2, ptr+3, all mod 4.
  - The first set bit wins.
- IDLE:
  - If req != 0 at an edge: sel <= winner, gnt <= one-hot(winner), gnt_valid <= 1, hcnt <= 0, go to GRANT.
  - Else remain in IDLE with outputs at their reset values (ptr retained).
- GRANT, release condition: req[sel]==0, OR hcnt==HOLD_MAX-1.
- GRANT, no release:
  - hcnt <= hcnt+1.
  - sel and gnt are unchanged.
- GRANT, release:
  - ptr <= sel+1 (mod 4, so 3 wraps to 0).
  - Re-arbitrate in the same edge using the new ptr.
  - If the new winner exists: sel/gnt <= new winner, hcnt <= 0, stay in GRANT. There is no bubble cycle.
  - If req is all zero: gnt_valid <= 0, gnt <= 0, go to IDLE; sel keeps its last value.
  - Timeout with only the current holder requesting: the same requester is re-granted and hcnt restarts at 0.
- Grant latency:
  - A req rising before edge k (in IDLE) gives gnt visible after edge k.
  - A req falling before edge k releases after edge k.
- Data path:
  - Every edge: dout <= mux(a,b,c,d) indexed by the sel value currently registered; dout_valid <= gnt_valid.
  - dout therefore lags gnt by one cycle.
  - When dout_valid=0, dout is held at its last value (0 after reset).
- Invariants:
  - gnt is always one-hot or zero; popcount(gnt) <= 1.
  - gnt_valid == |gnt.
  - hcnt never exceeds HOLD_MAX-1.
  - Any continuously requesting requester is granted within 3*HOLD_MAX+1 cycles.
- Requests are level signals. No acknowledge is required beyond observing gnt.

Test Plan:
- Reset: assert rst for 2 cycles with req=4'b1111 -> sel=0, gnt=0, gnt_valid=0, dout=0, dout_valid=0. The first edge after rst deasserts gives gnt=4'b0001.
- Single requester: req=4'b0010, b=1, others 0 -> gnt=4'b0010 after 1 edge, dout=1 with dout_valid=1 one edge later. Drop req -> gnt=0 after next edge.
- Fair rotation with HOLD_MAX=4, req=4'b1111 held -> grant sequence a,b,c,d,a, each held exactly 4 cycles. No idle cycle between grants; sel wraps 3->0.
- Early release: req=4'b0101 with a granted; clear req[0] after 2 cycles -> gnt=4'b0100 on the next edge, and ptr now favours c/d ahead of a.
- Timeout re-grant: only req[3] held for 20 cycles, HOLD_MAX=8 -> gnt stays 4'b1000 throughout, gnt_valid never drops, hcnt restarts every 8 cycles.
- Reset mid-grant: during c's grant, pulse rst for 1 cycle -> all outputs 0 on that edge. Afterwards arbitration restarts at ptr=0, so with req=4'b1100, c (not d) is granted first.
